// File: rtl/param_down_counter.sv
// Loadable down-counter/timer with start/done handshake, saturating load,
// abort, count enable and optional auto-reload of the latched start value.
module param_down_counter #(
    parameter int COUNT       = 16,
    parameter bit AUTO_RELOAD = 1'b0,
    localparam int W          = $clog2(COUNT)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         abort,
    output logic [W-1:0] count,
    output logic         busy,
    output logic         cout,
    output logic         done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [W-1:0] MAX_VAL  = W'(COUNT - 1);
    localparam logic [W-1:0] ZERO_VAL = '0;
    localparam logic [W-1:0] ONE_VAL  = W'(1);

    // Clamp an out-of-range load to the largest representable count.
    function automatic logic [W-1:0] sat(input logic [W-1:0] v);
        if (v > MAX_VAL) begin
            return MAX_VAL;
        end else begin
            return v;
        end
    endfunction

    state_t       state_r, state_s;
    logic [W-1:0] count_r, count_s;
    logic [W-1:0] reload_r, reload_s;
    logic         done_r, done_s;

    // Next-state decode: abort beats start beats en; done defaults low.
    always_comb begin
        state_s  = state_r;
        count_s  = count_r;
        reload_s = reload_r;
        done_s   = 1'b0;
        if (abort) begin
            if (state_r == ST_RUN) begin
                state_s = ST_IDLE;
                count_s = ZERO_VAL;
            end else begin
                state_s = state_r;
            end
        end else if (start) begin
            count_s  = sat(load_val);
            reload_s = sat(load_val);
            state_s  = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (!en) begin
                        state_s = ST_RUN;
                    end else if (count_r != ZERO_VAL) begin
                        count_s = count_r - ONE_VAL;
                    end else begin
                        // Terminal count consumed: zero never wraps to all-ones.
                        done_s = 1'b1;
                        if (AUTO_RELOAD) begin
                            count_s = sat(reload_r);
                        end else begin
                            state_s = ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s = ST_IDLE;
                    count_s = ZERO_VAL;
                end
            endcase
        end
    end

    // State, count, reload and done registers with async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            count_r  <= '0;
            reload_r <= '0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            count_r  <= count_s;
            reload_r <= reload_s;
            done_r   <= done_s;
        end
    end

    assign count = count_r;
    assign busy  = (state_r == ST_RUN);
    assign cout  = busy && (count_r == ZERO_VAL);
    assign done  = done_r;

endmodule

// File: tb/tb_param_down_counter.sv
// Directed bench for param_down_counter: three instances share stimulus
// (COUNT=16, COUNT=10, COUNT=16 with auto-reload).
module tb_param_down_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] load_val;
    logic       en;
    logic       abort;

    logic [3:0] c0, c1, c2;
    logic       b0, b1, b2;
    logic       co0, co1, co2;
    logic       d0, d1, d2;

    int tests = 0;
    int fails = 0;

    param_down_counter #(.COUNT(16), .AUTO_RELOAD(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .en(en),
        .abort(abort), .count(c0), .busy(b0), .cout(co0), .done(d0));
    param_down_counter #(.COUNT(10), .AUTO_RELOAD(1'b0)) u1 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .en(en),
        .abort(abort), .count(c1), .busy(b1), .cout(co1), .done(d1));
    param_down_counter #(.COUNT(16), .AUTO_RELOAD(1'b1)) u2 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .en(en),
        .abort(abort), .count(c2), .busy(b2), .cout(co2), .done(d2));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] st_cnt  [8];
        logic       st_en   [8];
        logic       st_cout [8];
        logic       st_done [8];
        st_en   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        st_cnt  = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
        st_cout = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        st_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; load_val = 4'd0; en = 1'b0; abort = 1'b0;
        tick();
        chk("rst_count", {28'd0, c0}, 32'd0);
        chk("rst_busy", {31'd0, b0}, 32'd0);
        chk("rst_done", {31'd0, d0}, 32'd0);
        chk("rst_cout", {31'd0, co0}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_count", {28'd0, c0}, 32'd0);

        // Basic sequence: load 5, count 5..0, done after the 6th enabled edge.
        start = 1'b1; load_val = 4'd5; en = 1'b1;
        tick();
        start = 1'b0;
        chk("basic_load", {28'd0, c0}, 32'd5);
        chk("basic_busy", {31'd0, b0}, 32'd1);
        chk("basic_cout0", {31'd0, co0}, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("basic_count", {28'd0, c0}, 32'(5 - k));
            chk("basic_nodone", {31'd0, d0}, 32'd0);
            chk("basic_cout", {31'd0, co0}, (k == 5) ? 32'd1 : 32'd0);
        end
        tick();
        chk("basic_done", {31'd0, d0}, 32'd1);
        chk("basic_idle", {31'd0, b0}, 32'd0);
        chk("basic_end_count", {28'd0, c0}, 32'd0);
        chk("basic_end_cout", {31'd0, co0}, 32'd0);
        tick();
        chk("basic_done_pulse", {31'd0, d0}, 32'd0);

        // Stall: load 3 with en pattern 1,0,0,1,1,0,1,1.
        start = 1'b1; load_val = 4'd3;
        tick();
        start = 1'b0;
        chk("stall_load", {28'd0, c0}, 32'd3);
        for (int k = 0; k < 8; k++) begin
            en = st_en[k];
            tick();
            chk("stall_count", {28'd0, c0}, {28'd0, st_cnt[k]});
            chk("stall_cout", {31'd0, co0}, {31'd0, st_cout[k]});
            chk("stall_done", {31'd0, d0}, {31'd0, st_done[k]});
        end
        chk("stall_idle", {31'd0, b0}, 32'd0);

        // Saturation on the COUNT=10 instance: 15 clamps to 9.
        start = 1'b1; load_val = 4'd15; en = 1'b1;
        tick();
        start = 1'b0;
        chk("sat_load10", {28'd0, c1}, 32'd9);
        chk("sat_load16", {28'd0, c0}, 32'd15);
        for (int k = 1; k <= 9; k++) tick();
        chk("sat_zero", {28'd0, c1}, 32'd0);
        chk("sat_cout", {31'd0, co1}, 32'd1);
        tick();
        chk("sat_done", {31'd0, d1}, 32'd1);
        chk("sat_no_underflow", {28'd0, c1}, 32'd0);
        chk("sat_idle", {31'd0, b1}, 32'd0);

        // Load of zero: terminal immediately, done after the first enabled edge.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1; load_val = 4'd0;
        tick();
        start = 1'b0;
        chk("zero_busy", {31'd0, b0}, 32'd1);
        chk("zero_cout", {31'd0, co0}, 32'd1);
        chk("zero_nodone", {31'd0, d0}, 32'd0);
        tick();
        chk("zero_done", {31'd0, d0}, 32'd1);
        chk("zero_count", {28'd0, c0}, 32'd0);
        chk("zero_idle", {31'd0, b0}, 32'd0);
        tick();
        chk("zero_no_underflow", {28'd0, c0}, 32'd0);

        // Abort at count 2.
        start = 1'b1; load_val = 4'd5;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        chk("abort_pre", {28'd0, c0}, 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", {31'd0, b0}, 32'd0);
        chk("abort_count", {28'd0, c0}, 32'd0);
        chk("abort_done", {31'd0, d0}, 32'd0);
        tick();
        chk("abort_no_done", {31'd0, d0}, 32'd0);

        // start and abort together: abort wins.
        start = 1'b1; abort = 1'b1; load_val = 4'd7;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", {31'd0, b0}, 32'd0);
        chk("sa_count", {28'd0, c0}, 32'd0);

        // Restart on a terminal edge: reload, no done.
        start = 1'b1; load_val = 4'd1;
        tick();
        start = 1'b0;
        tick();
        chk("rs_term", {31'd0, co0}, 32'd1);
        start = 1'b1; load_val = 4'd4;
        tick();
        start = 1'b0;
        chk("rs_count", {28'd0, c0}, 32'd4);
        chk("rs_nodone", {31'd0, d0}, 32'd0);
        chk("rs_busy", {31'd0, b0}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Auto-reload: load 2, sequence 2,1,0,2,1,0,... with periodic done.
        start = 1'b1; load_val = 4'd2;
        tick();
        start = 1'b0;
        chk("ar_load", {28'd0, c2}, 32'd2);
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("ar_count", {28'd0, c2}, 32'(2 - (k % 3)));
            chk("ar_done", {31'd0, d2}, (k % 3 == 0) ? 32'd1 : 32'd0);
            chk("ar_busy", {31'd0, b2}, 32'd1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ar_abort", {31'd0, b2}, 32'd0);

        // Async reset between edges at count 4.
        start = 1'b1; load_val = 4'd9;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("ar_pre", {28'd0, c0}, 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_count", {28'd0, c0}, 32'd0);
        chk("arst_busy", {31'd0, b0}, 32'd0);
        chk("arst_done", {31'd0, d0}, 32'd0);
        chk("arst_cout", {31'd0, co0}, 32'd0);
        #2;
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_count", {28'd0, c0}, 32'd0);
        chk("post_rst_busy", {31'd0, b0}, 32'd0);
        chk("post_rst_done", {31'd0, d0}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
